pipe_stall_ctrl: RTL and testbench

- Central stall controller for the 5-stage pipeline.
- Merges stall requests from ID (load-use hazard), EX (multi-cycle ops) and MEM (memory wait) into one per-stage stall vector.
- The vector drives the PC, if_id, id_ex, ex_mem and mem_wb registers.
- Contains the sequencer FSM that holds EX for a programmed number of cycles during multi-cycle ops (madd/msub/div) and signals completion.

---
 rtl/pipe_stall_ctrl_pkg.sv | 32 +++
 rtl/pipe_stall_ctrl_mc_seq.sv | 76 +++++++
 rtl/pipe_stall_ctrl.sv | 63 ++++++
 tb/tb_pipe_stall_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types, stall patterns and sequencer state encodings for pipe_stall_ctrl.
// The stall bit map is fixed: 0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB.
package pipe_stall_ctrl_pkg;

  localparam int STALL_W_DFLT  = 6;
  localparam int MC_CNT_W_DFLT = 6;

  typedef logic [STALL_W_DFLT-1:0]  stall_bus_t;
  typedef logic [MC_CNT_W_DFLT-1:0] mc_cnt_bus_t;

  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    MC_IDLE = 2'b00,
    MC_RUN  = 2'b01,
    MC_DONE = 2'b10
  } mc_state_t;

  // Deepest requester wins: MEM over EX over ID.
  function automatic stall_bus_t stall_pattern(input logic req_id,
                                               input logic req_ex,
                                               input logic req_mem);
    if (req_mem)     return STALL_MEM;
    else if (req_ex) return STALL_EX;
    else if (req_id) return STALL_ID;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_mc_seq.sv
// Multi-cycle op sequencer: holds EX for max(N,1) RUN cycles, then DONE until MEM drains.
// Cancel (priority over start) or rst returns to IDLE with no done pulse.
module mc_seq
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MC_CNT_W = MC_CNT_W_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_mc_start,
  input  logic [MC_CNT_W-1:0] ex_mc_cycles,
  input  logic                ex_mc_cancel,
  input  logic                stallreq_mem,
  output logic                ex_stall_req,
  output logic                busy,
  output logic                done
);

  mc_state_t           state;
  logic [MC_CNT_W-1:0] cnt;
  logic                busy_q;
  logic                done_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MC_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (ex_mc_cancel) begin
      state  <= MC_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        MC_IDLE: begin
          if (ex_mc_start) begin
            state  <= MC_RUN;
            cnt    <= (ex_mc_cycles == '0) ? '0 : ex_mc_cycles - 1'b1;
            busy_q <= 1'b1;
          end
        end
        MC_RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state  <= MC_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        MC_DONE: begin
          if (!stallreq_mem) begin
            state  <= MC_IDLE;
            done_q <= 1'b0;
          end
        end
        default: begin
          state  <= MC_IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // The start cycle itself stalls so id_ex keeps the op in EX; DONE does not.
  assign ex_stall_req = ~rst & (((state == MC_IDLE) & ex_mc_start & ~ex_mc_cancel) |
                                (state == MC_RUN));
  assign busy = busy_q & ~rst;
  assign done = done_q & ~rst;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall controller: priority-merges ID/EX/MEM requests into the stall vector.
// Define PIPE_STALL_STATS_EN to enable the saturating stall_cycles statistics counter.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MC_CNT_W = MC_CNT_W_DFLT,
  parameter int STALL_W  = STALL_W_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                stallreq_mem,
  input  logic                ex_mc_start,
  input  logic [MC_CNT_W-1:0] ex_mc_cycles,
  input  logic                ex_mc_cancel,
  output logic [STALL_W-1:0]  stall,
  output logic                ex_mc_busy,
  output logic                ex_mc_done,
  output logic [31:0]         stall_cycles
);

  logic       ex_stall_req;
  stall_bus_t stall_vec;

  mc_seq #(
    .MC_CNT_W (MC_CNT_W)
  ) u_mc_seq (
    .clk          (clk),
    .rst          (rst),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_cycles (ex_mc_cycles),
    .ex_mc_cancel (ex_mc_cancel),
    .stallreq_mem (stallreq_mem),
    .ex_stall_req (ex_stall_req),
    .busy         (ex_mc_busy),
    .done         (ex_mc_done)
  );

  // NOTE: a default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    stall_vec = STALL_NONE;
    if (!rst) stall_vec = stall_pattern(stallreq_id, ex_stall_req, stallreq_mem);
  end

  assign stall = STALL_W'(stall_vec);

`ifdef PIPE_STALL_STATS_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (stall_vec[0] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl; inputs change 1 time unit after
// the rising edge and outputs are checked 1 unit later, well clear of the next edge.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_mem;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_cycles;
  logic        ex_mc_cancel;
  logic [5:0]  stall;
  logic        ex_mc_busy;
  logic        ex_mc_done;
  logic [31:0] stall_cycles;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_mem (stallreq_mem),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_cycles (ex_mc_cycles),
    .ex_mc_cancel (ex_mc_cancel),
    .stall        (stall),
    .ex_mc_busy   (ex_mc_busy),
    .ex_mc_done   (ex_mc_done),
    .stall_cycles (stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic [5:0] exp_stall,
                           input logic exp_busy, input logic exp_done);
    check({tag, ".stall"}, 32'(stall), 32'(exp_stall));
    check({tag, ".busy"},  32'(ex_mc_busy), 32'(exp_busy));
    check({tag, ".done"},  32'(ex_mc_done), 32'(exp_done));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 1'b0; stallreq_mem = 1'b0;
    ex_mc_start = 1'b0; ex_mc_cycles = 6'd0; ex_mc_cancel = 1'b0;
    cyc();
    // rst masks every requester combinationally
    stallreq_mem = 1'b1; stallreq_id = 1'b1; ex_mc_start = 1'b1; settle();
    check_out("rst_mask", 6'b000000, 1'b0, 1'b0);
    stallreq_mem = 1'b0; stallreq_id = 1'b0; ex_mc_start = 1'b0;
    cyc();
    rst = 1'b0; settle();
    check_out("reset", 6'b000000, 1'b0, 1'b0);
    check("reset.stats", stall_cycles, 32'h0);

    // 1: single-cycle load-use stall
    cyc(); stallreq_id = 1'b1; settle();
    check_out("id_req", 6'b000111, 1'b0, 1'b0);
    cyc(); stallreq_id = 1'b0; settle();
    check_out("id_after", 6'b000000, 1'b0, 1'b0);

    // 2: N=3, start re-asserted mid-RUN must be ignored
    cyc(); ex_mc_start = 1'b1; ex_mc_cycles = 6'd3; settle();
    check_out("n3.t0", 6'b001111, 1'b0, 1'b0);
    cyc(); ex_mc_start = 1'b0; settle();
    check_out("n3.t1", 6'b001111, 1'b1, 1'b0);
    cyc(); ex_mc_start = 1'b1; ex_mc_cycles = 6'd1; settle();
    check_out("n3.t2", 6'b001111, 1'b1, 1'b0);
    cyc(); ex_mc_start = 1'b0; settle();
    check_out("n3.t3", 6'b001111, 1'b1, 1'b0);
    cyc();
    check_out("n3.t4", 6'b000000, 1'b0, 1'b1);
    cyc();
    check_out("n3.t5", 6'b000000, 1'b0, 1'b0);

    // 3: N=0 behaves as N=1
    cyc(); ex_mc_start = 1'b1; ex_mc_cycles = 6'd0; settle();
    check_out("n0.t0", 6'b001111, 1'b0, 1'b0);
    cyc(); ex_mc_start = 1'b0; settle();
    check_out("n0.t1", 6'b001111, 1'b1, 1'b0);
    cyc();
    check_out("n0.t2", 6'b000000, 1'b0, 1'b1);
    cyc();
    check_out("n0.t3", 6'b000000, 1'b0, 1'b0);

    // 4: N=5, cancel in the second RUN cycle
    cyc(); ex_mc_start = 1'b1; ex_mc_cycles = 6'd5; settle();
    check_out("cancel.t0", 6'b001111, 1'b0, 1'b0);
    cyc(); ex_mc_start = 1'b0; settle();
    check_out("cancel.t1", 6'b001111, 1'b1, 1'b0);
    cyc(); ex_mc_cancel = 1'b1; settle();
    check_out("cancel.t2", 6'b001111, 1'b1, 1'b0);
    cyc(); ex_mc_cancel = 1'b0; settle();
    check_out("cancel.t3", 6'b000000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check_out("cancel.after", 6'b000000, 1'b0, 1'b0);
    end
    // cancel beats start in IDLE
    cyc(); ex_mc_start = 1'b1; ex_mc_cancel = 1'b1; settle();
    check_out("cancel_start", 6'b000000, 1'b0, 1'b0);
    cyc(); ex_mc_start = 1'b0; ex_mc_cancel = 1'b0; settle();
    check_out("cancel_start.next", 6'b000000, 1'b0, 1'b0);

    // 5: N=2, MEM wait holds DONE; MEM during RUN shows MEM pattern
    cyc(); ex_mc_start = 1'b1; ex_mc_cycles = 6'd2; settle();
    check_out("mem.t0", 6'b001111, 1'b0, 1'b0);
    cyc(); ex_mc_start = 1'b0; stallreq_mem = 1'b1; settle();
    check_out("mem.t1", 6'b011111, 1'b1, 1'b0);
    cyc(); stallreq_mem = 1'b0; settle();
    check_out("mem.t2", 6'b001111, 1'b1, 1'b0);
    cyc(); stallreq_mem = 1'b1; settle();
    check_out("mem.t3", 6'b011111, 1'b0, 1'b1);
    cyc(); stallreq_id = 1'b1; settle();
    check_out("mem.t4", 6'b011111, 1'b0, 1'b1);
    cyc(); stallreq_id = 1'b0; settle();
    check_out("mem.t5", 6'b011111, 1'b0, 1'b1);
    cyc(); stallreq_mem = 1'b0; settle();
    check_out("mem.t6", 6'b000000, 1'b0, 1'b1);
    cyc();
    check_out("mem.t7", 6'b000000, 1'b0, 1'b0);

    // 6: rst mid-RUN, N=10
    cyc(); ex_mc_start = 1'b1; ex_mc_cycles = 6'd10; settle();
    check_out("rst_run.t0", 6'b001111, 1'b0, 1'b0);
    cyc(); ex_mc_start = 1'b0; settle();
    check_out("rst_run.t1", 6'b001111, 1'b1, 1'b0);
    cyc();
    check_out("rst_run.t2", 6'b001111, 1'b1, 1'b0);
    cyc(); rst = 1'b1; settle();
    check_out("rst_run.rst", 6'b000000, 1'b0, 1'b0);
    cyc(); rst = 1'b0; settle();
    check_out("rst_run.t4", 6'b000000, 1'b0, 1'b0);
    check("rst_run.stats", stall_cycles, 32'h0);
    cyc();
    check_out("rst_run.t5", 6'b000000, 1'b0, 1'b0);

    // statistics over a fresh N=3 op: stall[0] high for exactly 4 cycles
    cyc(); ex_mc_start = 1'b1; ex_mc_cycles = 6'd3; settle();
    cyc(); ex_mc_start = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check_out("stats.idle", 6'b000000, 1'b0, 1'b0);
`ifdef PIPE_STALL_STATS_EN
    check("stats.count", stall_cycles, 32'd4);
`else
    check("stats.tied", stall_cycles, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
